// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/stall/context-switch control signal bundle
interface pipeline_ctrl_if;
   logic        i_busywait;
   logic        d_busywait;
   logic        branch_jump_signal;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        ex_d_mem_r;
   logic [4:0]  ex_write_address;
   logic        ctx_switch_req;
   logic        pc_hold;
   logic        if_id_hold;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        stage_busywait;
   logic        ctx_switch_ack;
   logic [1:0]  state;
   logic [15:0] stall_cycles;

   modport master (
      output i_busywait, d_busywait, branch_jump_signal, id_rs1, id_rs2,
             ex_d_mem_r, ex_write_address, ctx_switch_req,
      input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, stage_busywait,
             ctx_switch_ack, state, stall_cycles
   );

   modport slave (
      input  i_busywait, d_busywait, branch_jump_signal, id_rs1, id_rs2,
             ex_d_mem_r, ex_write_address, ctx_switch_req,
      output pc_hold, if_id_hold, if_id_flush, id_ex_flush, stage_busywait,
             ctx_switch_ack, state, stall_cycles
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard, stall and context-switch drain controller
module pipeline_ctrl (
   input  logic            clk,
   input  logic            reset,
   pipeline_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      SWITCH  = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  drain_cnt_q, drain_cnt_d;
   logic [15:0] stall_q;
   logic        load_use;
   logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, stage_busywait, ctx_switch_ack;

   assign load_use = bus.ex_d_mem_r && (bus.ex_write_address != 5'd0) &&
                     ((bus.ex_write_address == bus.id_rs1) || (bus.ex_write_address == bus.id_rs2));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         drain_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // A data-cache miss freezes the whole pipeline, including the counter.
   always_ff @(posedge clk) begin
      if (reset)
         stall_q <= 16'd0;
      else if (pc_hold && !bus.d_busywait && (stall_q != 16'hFFFF))
         stall_q <= stall_q + 16'd1;
   end

   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      pc_hold        = 1'b0;
      if_id_hold     = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      stage_busywait = 1'b0;
      ctx_switch_ack = 1'b0;

      if (reset) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         ctx_switch_ack = (state_q == SWITCH) && bus.ctx_switch_req;
         if (bus.d_busywait) begin
            stage_busywait = 1'b1;
            pc_hold        = 1'b1;
            if_id_hold     = 1'b1;
         end else if (bus.branch_jump_signal) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if ((state_q == RUN) && load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
         end else if (((state_q == RUN) && bus.i_busywait) ||
                      (state_q == DRAIN) || (state_q == SWITCH)) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
         end
      end

      case (state_q)
         RUN: begin
            if (!bus.d_busywait && bus.ctx_switch_req) begin
               state_d     = DRAIN;
               drain_cnt_d = 3'd0;
            end
         end
         DRAIN: begin
            // Request deassertion is ignored here; the drain always completes.
            if (!bus.d_busywait) begin
               drain_cnt_d = drain_cnt_q + 3'd1;
               if (drain_cnt_q == 3'd3)
                  state_d = SWITCH;
            end
         end
         SWITCH: begin
            if (!bus.d_busywait && !bus.ctx_switch_req)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign bus.pc_hold        = pc_hold;
   assign bus.if_id_hold     = if_id_hold;
   assign bus.if_id_flush    = if_id_flush;
   assign bus.id_ex_flush    = id_ex_flush;
   assign bus.stage_busywait = stage_busywait;
   assign bus.ctx_switch_ack = ctx_switch_ack;
   assign bus.state          = state_q;
   assign bus.stall_cycles   = stall_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl with a behavioural model
module tb_pipeline_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_ctrl_if bus();
   pipeline_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic       r, d, ib, bj, req, ld;
      logic [4:0] rs1, rs2, wa;
   } stim_t;

   typedef struct packed {
      logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, stage_busywait, ack;
      logic [1:0]  state;
      logic [15:0] stalls;
   } resp_t;

   resp_t exp_q[$];
   int checks = 0;
   int passes = 0;
   int cyc = 0;

   // Model: mode number, drain cycles still owed, saturating stall tally
   int m_state = 0;
   int m_drain_left = 0;
   int m_stalls = 0;

   function automatic stim_t idle();
      stim_t s;
      s.r = 0; s.d = 0; s.ib = 0; s.bj = 0; s.req = 0; s.ld = 0;
      s.rs1 = 0; s.rs2 = 0; s.wa = 0;
      return s;
   endfunction

   task automatic step(input stim_t s);
      resp_t e;
      bit hazard;
      @(posedge clk); #1;
      reset = s.r;
      bus.d_busywait = s.d; bus.i_busywait = s.ib; bus.branch_jump_signal = s.bj;
      bus.ctx_switch_req = s.req; bus.ex_d_mem_r = s.ld;
      bus.id_rs1 = s.rs1; bus.id_rs2 = s.rs2; bus.ex_write_address = s.wa;

      hazard = s.ld && (s.wa != 0) && ((s.wa == s.rs1) || (s.wa == s.rs2));
      e = '0;
      e.state  = m_state[1:0];
      e.stalls = m_stalls[15:0];
      if (s.r) begin
         e.if_id_flush = 1; e.id_ex_flush = 1;
      end else begin
         e.ack = (m_state == 2) && s.req;
         if (s.d) begin
            e.pc_hold = 1; e.if_id_hold = 1; e.stage_busywait = 1;
         end else if (s.bj) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
         end else if (m_state == 0 && hazard) begin
            e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
         end else if (m_state != 0 || s.ib) begin
            e.pc_hold = 1; e.if_id_flush = 1;
         end
      end
      exp_q.push_back(e);

      if (s.r) begin
         m_state = 0; m_stalls = 0;
      end else if (!s.d) begin
         if (e.pc_hold && m_stalls < 65535) m_stalls++;
         case (m_state)
            0: if (s.req) begin m_state = 1; m_drain_left = 4; end
            1: begin m_drain_left--; if (m_drain_left == 0) m_state = 2; end
            default: if (!s.req) m_state = 0;
         endcase
      end
   endtask

   always @(negedge clk) begin : monitor
      resp_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {bus.pc_hold, bus.if_id_hold, bus.if_id_flush, bus.id_ex_flush,
              bus.stage_busywait, bus.ctx_switch_ack, bus.state, bus.stall_cycles};
         checks++;
         if (g !== e)
            $display("FAIL cyc%0d outputs: got pc=%b ifh=%b iff=%b idf=%b sb=%b ack=%b st=%0d stalls=%0d exp pc=%b ifh=%b iff=%b idf=%b sb=%b ack=%b st=%0d stalls=%0d",
                     cyc, g.pc_hold, g.if_id_hold, g.if_id_flush, g.id_ex_flush, g.stage_busywait,
                     g.ack, g.state, g.stalls, e.pc_hold, e.if_id_hold, e.if_id_flush, e.id_ex_flush,
                     e.stage_busywait, e.ack, e.state, e.stalls);
         else
            passes++;
         cyc++;
      end
   end

   initial begin
      stim_t s;
      logic req;
      reset = 1;
      bus.d_busywait = 0; bus.i_busywait = 0; bus.branch_jump_signal = 0;
      bus.ctx_switch_req = 0; bus.ex_d_mem_r = 0;
      bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_write_address = 0;
      repeat (2) @(posedge clk);

      s = idle(); s.r = 1; step(s); step(s);
      s = idle(); step(s);

      // Load-use on rs2, then a load to x0 which must not stall
      s = idle(); s.ld = 1; s.wa = 5; s.rs2 = 5; step(s);
      s = idle(); step(s);
      s = idle(); s.ld = 1; s.wa = 0; step(s);
      s = idle(); s.ld = 1; s.wa = 7; s.rs1 = 7; s.ib = 1; step(s);

      // Freeze beats branch and load-use, branch follows when the freeze lifts
      s = idle(); s.d = 1; s.bj = 1; s.ld = 1; s.wa = 3; s.rs1 = 3; step(s); step(s);
      s = idle(); s.bj = 1; step(s);
      s = idle(); step(s);

      // Plain context switch
      s = idle(); s.req = 1;
      for (int i = 0; i < 7; i++) step(s);
      s = idle(); step(s); step(s);

      // Drain interrupted by a 3-cycle freeze, request dropped mid-drain
      s = idle(); s.req = 1; step(s); step(s); step(s);
      s.d = 1; step(s); step(s); step(s);
      s = idle(); s.bj = 1; step(s);
      s = idle();
      for (int i = 0; i < 4; i++) step(s);

      // Reset while in SWITCH with the request still high
      s = idle(); s.req = 1;
      for (int i = 0; i < 6; i++) step(s);
      s.r = 1; step(s);
      s.r = 0; step(s); step(s);
      s = idle();
      for (int i = 0; i < 7; i++) step(s);

      // Randomized traffic
      req = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) req = ~req;
         s.r   = ($urandom_range(0, 99) == 0);
         s.d   = ($urandom_range(0, 5) == 0);
         s.ib  = ($urandom_range(0, 4) == 0);
         s.bj  = ($urandom_range(0, 7) == 0);
         s.req = req;
         s.ld  = ($urandom_range(0, 1) == 0);
         s.rs1 = 5'($urandom_range(0, 3));
         s.rs2 = 5'($urandom_range(0, 3));
         s.wa  = 5'($urandom_range(0, 3));
         step(s);
      end

      // Counter saturation, then reset clears it
      s = idle(); s.r = 1; step(s);
      s = idle(); s.ib = 1;
      for (int i = 0; i < 65538; i++) step(s);
      s = idle(); s.r = 1; step(s);
      s = idle(); step(s); step(s);

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0)
         $display("FAIL scoreboard_drain: got %0d pending, exp 0", exp_q.size());
      else
         passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have ports i_busywait, d_busywait  in  1 each  instruction- and data-cache miss stalls.
REQ-004 SHALL have port branch_jump_signal  in  1  taken branch/jump resolved in EX.
REQ-005 SHALL have ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports ex_d_mem_r  in  1 and ex_write_address  in  5  load flag and destination of the instruction in EX.
REQ-007 SHALL have port ctx_switch_req  in  1  level request from the OS/cache-switch logic to drain the pipeline.
REQ-008 SHALL have outputs pc_hold, if_id_hold, if_id_flush, id_ex_flush, stage_busywait  1 each  pipeline-register controls; stage_busywait drives busywait of ID/EX, EX/MEM and MEM/WB.
REQ-009 SHALL have outputs ctx_switch_ack  1  pipeline empty and frozen; state  2  current FSM state; stall_cycles  16  performance counter.

Function
REQ-010 SHALL implement FSM states RUN=0, DRAIN=1, SWITCH=2 in a registered state variable; encoding 3 unused and recovers to RUN next cycle.
REQ-011 SHALL compute all control outputs combinationally from state and current inputs (zero-cycle latency), with priority d_busywait > branch_jump_signal > load-use > i_busywait.
REQ-012 SHALL, when d_busywait=1 in any state, assert stage_busywait, pc_hold and if_id_hold, deassert all flushes, and freeze state, drain count and stall_cycles.
REQ-013 SHALL, when branch_jump_signal=1 and d_busywait=0, assert if_id_flush and id_ex_flush and deassert pc_hold so the PC loads the target.
REQ-014 SHALL detect load-use hazard = ex_d_mem_r & (ex_write_address!=0) & (ex_write_address==id_rs1 | ex_write_address==id_rs2).
REQ-015 SHALL, in RUN with load-use and no higher-priority event, assert pc_hold, if_id_hold and id_ex_flush for exactly that cycle (one bubble).
REQ-016 SHALL, in RUN with i_busywait=1 and no higher-priority event, assert pc_hold and if_id_flush (bubble into ID) while later stages advance.
REQ-017 SHALL transition RUN->DRAIN when ctx_switch_req=1 and d_busywait=0, clearing a 3-bit drain count to 0.
REQ-018 SHALL in DRAIN assert pc_hold and if_id_flush every cycle (except REQ-013 cycles, which deassert pc_hold), increment drain count each non-frozen cycle, and move to SWITCH after the count reaches 4.
REQ-019 SHALL in SWITCH assert ctx_switch_ack, pc_hold and if_id_flush; move to RUN on the first cycle ctx_switch_req=0, ack deasserting that same cycle.
REQ-020 SHALL ignore ctx_switch_req deassertion during DRAIN; the drain completes into SWITCH.
REQ-021 SHALL increment stall_cycles by 1 on every non-reset cycle where pc_hold=1, saturating at 16'hFFFF.

Reset
REQ-022 SHALL on reset set state=RUN, drain count=0, stall_cycles=0; with reset asserted, outputs pc_hold=0, if_id_hold=0, if_id_flush=1, id_ex_flush=1, stage_busywait=0, ctx_switch_ack=0.
REQ-023 SHALL let reset mid-DRAIN or mid-SWITCH abort to RUN on the next edge, ack low, regardless of ctx_switch_req.

Verification
REQ-024 Load-use: ex_d_mem_r=1, ex_write_address=5, id_rs2=5 for 1 cycle -> pc_hold=if_id_hold=id_ex_flush=1 that cycle only, stall_cycles +1; with ex_write_address=0 -> no stall.
REQ-025 Simultaneous: d_busywait=1 with branch_jump_signal=1 and load-use -> only freeze (stage_busywait=1, flushes 0); drop d_busywait -> branch flush next cycle.
REQ-026 Context switch: ctx_switch_req=1 from RUN, no stalls -> state 1 for 4 cycles then 2, ack=1; drop req -> state 0, ack=0 same cycle.
REQ-027 Drain with d_busywait=1 for 3 cycles mid-DRAIN -> SWITCH entry delayed by exactly 3 cycles.
REQ-028 Saturation: preload via 65535 held cycles with i_busywait=1 -> stall_cycles=16'hFFFF, stays after further stalls; reset -> 0.
REQ-029 Reset in SWITCH with req=1 -> state=0, ack=0 next edge; re-enters DRAIN the following cycle.
